hwpf_nl_issue_ctrl: RTL and testbench

Issue controller for the Sargantana next-line prefetcher. It turns CPU miss addresses into next-line prefetch candidates and filters them against the recent-address history FIFO (`hwpf_fifo`). It also drives that FIFO's insert, lock and flush inputs, buffers accepted candidates, and issues them to the memory side through a valid/ready handshake under an outstanding-request limit.

---
 rtl/hwpf_nl_issue_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_hwpf_nl_issue_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpf_nl_issue_ctrl.sv
// hwpf_nl_issue_ctrl
//   Issue controller for the next-line hardware prefetcher. Each valid CPU
//   miss lane produces a candidate (next cache line). Candidates are deduped
//   across lanes and filtered against the history FIFO and the pending
//   buffer. New candidates go into a small circular pending buffer. Every
//   surviving candidate is pushed to history, compacted onto the low take
//   lanes. The buffered candidates are issued over a valid/ready handshake,
//   and the number issued but not yet done is capped at MAX_OUTST.
//
// Ports
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   enable_i, flush_i  prefetcher enable; flush drops pending + history
//   miss_valid_i/addr  per-lane miss address from the CPU
//   hist_data_i/valid  history FIFO contents (data_cpu_o / data_valid_o)
//   hist_take_o/addr_o history push lanes (take_req_i / cpu_req_i)
//   hist_lock_o        history lock_i, high whenever state is not ACTIVE
//   hist_flush_o       history flush_i, a combinational copy of flush_i
//   pf_valid_o/addr_o  prefetch request, held stable until accepted
//   pf_ready_i         memory side accepts the request
//   pf_done_i          one outstanding prefetch has completed
//   busy_o             FSM not idle
//   drop_cnt_o         saturating count of candidates refused for lack of space
module hwpf_nl_issue_ctrl #(
  parameter int unsigned INSERTS    = 2,
  parameter int unsigned HIST_DEPTH = 8,
  parameter int unsigned PEND_DEPTH = 4,
  parameter int unsigned MAX_OUTST  = 2,
  parameter int unsigned LINE_BYTES = 64,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                enable_i,
  input  logic                                flush_i,
  input  logic [INSERTS-1:0]                  miss_valid_i,
  input  logic [INSERTS-1:0][ADDR_W-1:0]      miss_addr_i,
  input  logic [HIST_DEPTH-1:0][ADDR_W-1:0]   hist_data_i,
  input  logic [HIST_DEPTH-1:0]               hist_valid_i,
  output logic [INSERTS-1:0]                  hist_take_o,
  output logic [INSERTS-1:0][ADDR_W-1:0]      hist_addr_o,
  output logic                                hist_lock_o,
  output logic                                hist_flush_o,
  output logic                                pf_valid_o,
  output logic [ADDR_W-1:0]                   pf_addr_o,
  input  logic                                pf_ready_i,
  input  logic                                pf_done_i,
  output logic                                busy_o,
  output logic [15:0]                         drop_cnt_o
);

  localparam int unsigned PW = $clog2(PEND_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned OW = 3;

  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_BYTES - 1);
  localparam logic [ADDR_W-1:0] LINE_INC  = ADDR_W'(LINE_BYTES);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;

  logic [1:0]                            state_q, state_d;
  logic [PW-1:0]                         head_q, head_d;
  logic [PW-1:0]                         tail_q, tail_d;
  logic [CW-1:0]                         cnt_q, cnt_d;
  logic [OW-1:0]                         outst_q, outst_d;
  logic [15:0]                           drop_q, drop_d;
  logic [PEND_DEPTH-1:0][ADDR_W-1:0]     mem_q;

  logic                                  active;
  logic                                  hs;
  logic                                  clear;
  logic [PEND_DEPTH-1:0]                 pend_vld;
  logic [INSERTS-1:0][ADDR_W-1:0]        cand;
  logic [INSERTS-1:0]                    live;
  logic [INSERTS-1:0]                    accept;
  logic [INSERTS-1:0]                    drop;
  logic [INSERTS-1:0]                    push;
  logic [PW-1:0]                         acc_slot [INSERTS];
  logic                                  lv;
  logic                                  hit;
  int unsigned                           free_slots;
  int unsigned                           n_acc;
  int unsigned                           n_drop;
  int unsigned                           rank;
  logic [PW-1:0]                         offs;
  logic [16:0]                           drop_sum;

  assign active = (state_q == S_ACTIVE);

  // Slot s holds a live entry when its distance from head is below count;
  // with a full buffer every slot qualifies.
  always_comb begin
    pend_vld = '0;
    offs     = '0;
    for (int unsigned s = 0; s < PEND_DEPTH; s++) begin
      offs        = PW'(s) - head_q;
      pend_vld[s] = ({1'b0, offs} < cnt_q);
    end
  end

  // Candidate generation, lane dedup, filtering and space allocation.
  // Space is taken from the registered count only, so a pop in the same
  // cycle never frees room for this cycle's candidates.
  always_comb begin
    live       = '0;
    accept     = '0;
    drop       = '0;
    push       = '0;
    cand       = '0;
    lv         = 1'b0;
    hit        = 1'b0;
    n_acc      = 0;
    n_drop     = 0;
    free_slots = PEND_DEPTH - 32'(cnt_q);
    for (int unsigned i = 0; i < INSERTS; i++) begin
      acc_slot[i] = '0;
      cand[i]     = (miss_addr_i[i] & ~LINE_MASK) + LINE_INC;
    end
    for (int unsigned i = 0; i < INSERTS; i++) begin
      lv = active && !flush_i && miss_valid_i[i];
      for (int unsigned j = 0; j < i; j++) begin
        if (live[j] && (cand[j] == cand[i])) lv = 1'b0;
      end
      live[i] = lv;
      hit = 1'b0;
      for (int unsigned h = 0; h < HIST_DEPTH; h++) begin
        if (hist_valid_i[h] && (hist_data_i[h] == cand[i])) hit = 1'b1;
      end
      for (int unsigned s = 0; s < PEND_DEPTH; s++) begin
        if (pend_vld[s] && (mem_q[s] == cand[i])) hit = 1'b1;
      end
      if (lv && !hit) begin
        if (n_acc < free_slots) begin
          accept[i]   = 1'b1;
          acc_slot[i] = tail_q + PW'(n_acc);
          n_acc       = n_acc + 1;
        end else begin
          drop[i] = 1'b1;
          n_drop  = n_drop + 1;
        end
      end
      push[i] = lv && !drop[i];
    end
  end

  // Compact history pushes onto the lowest take lanes.
  always_comb begin
    hist_take_o = '0;
    hist_addr_o = '0;
    rank        = 0;
    for (int unsigned i = 0; i < INSERTS; i++) begin
      if (push[i]) begin
        for (int unsigned k = 0; k < INSERTS; k++) begin
          if (k == rank) begin
            hist_take_o[k] = 1'b1;
            hist_addr_o[k] = cand[i];
          end
        end
        rank = rank + 1;
      end
    end
  end

  assign hist_lock_o  = !active;
  assign hist_flush_o = flush_i;
  assign busy_o       = (state_q != S_IDLE);
  assign drop_cnt_o   = drop_q;

  assign pf_valid_o = active && (cnt_q != '0) && (outst_q < OW'(MAX_OUTST));
  assign pf_addr_o  = pf_valid_o ? mem_q[head_q] : '0;
  assign hs         = pf_valid_o && pf_ready_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (enable_i && !flush_i) state_d = S_ACTIVE;
      S_ACTIVE: if (flush_i || !enable_i) state_d = S_DRAIN;
      S_DRAIN:  if ((outst_q == '0) && !flush_i) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Pending buffer empties on the edge where flush is seen or ACTIVE is left.
  always_comb begin
    clear  = flush_i || (state_d != S_ACTIVE);
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (clear) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      head_d = head_q + PW'(hs);
      tail_d = tail_q + PW'(n_acc);
      cnt_d  = cnt_q + CW'(n_acc) - CW'(hs);
    end
  end

  // A done with nothing outstanding is ignored.
  always_comb begin
    outst_d = outst_q;
    if (hs && !(pf_done_i && (outst_q != '0))) begin
      outst_d = outst_q + 1'b1;
    end else if (!hs && pf_done_i && (outst_q != '0)) begin
      outst_d = outst_q - 1'b1;
    end
  end

  always_comb begin
    drop_sum = {1'b0, drop_q} + 17'(n_drop);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      outst_q <= '0;
      drop_q  <= '0;
      mem_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
      if (!clear) begin
        for (int unsigned i = 0; i < INSERTS; i++) begin
          if (accept[i]) mem_q[acc_slot[i]] <= cand[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_hwpf_nl_issue_ctrl.sv
module tb_hwpf_nl_issue_ctrl;

  localparam int NI = 2;
  localparam int NH = 8;
  localparam int ND = 4;
  localparam int MO = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic en, fl, rdy, done;
  logic [NI-1:0] mv;
  logic [NI-1:0][31:0] ma;
  logic [NH-1:0][31:0] hd;
  logic [NH-1:0] hv;

  logic [NI-1:0] hist_take_o;
  logic [NI-1:0][31:0] hist_addr_o;
  logic hist_lock_o, hist_flush_o, pf_valid_o, busy_o;
  logic [31:0] pf_addr_o;
  logic [15:0] drop_cnt_o;

  // stimulus for the next step
  logic s_en, s_fl, s_rdy, s_done;
  logic [NI-1:0] s_mv;
  logic [NI-1:0][31:0] s_ma;
  logic [NH-1:0][31:0] s_hd;
  logic [NH-1:0] s_hv;

  // reference model: 0 idle, 1 active, 2 drain
  int m_state, m_outst, m_drop;
  logic [31:0] q[$];

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  hwpf_nl_issue_ctrl #(
    .INSERTS(NI), .HIST_DEPTH(NH), .PEND_DEPTH(ND), .MAX_OUTST(MO),
    .LINE_BYTES(64), .ADDR_W(32)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .flush_i(fl),
    .miss_valid_i(mv), .miss_addr_i(ma), .hist_data_i(hd), .hist_valid_i(hv),
    .hist_take_o(hist_take_o), .hist_addr_o(hist_addr_o),
    .hist_lock_o(hist_lock_o), .hist_flush_o(hist_flush_o),
    .pf_valid_o(pf_valid_o), .pf_addr_o(pf_addr_o),
    .pf_ready_i(rdy), .pf_done_i(done),
    .busy_o(busy_o), .drop_cnt_o(drop_cnt_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] next_line(input logic [31:0] a);
    logic [31:0] r;
    r = ((a >> 6) + 32'd1) << 6;
    return r;
  endfunction

  task automatic clear_stim();
    s_en = 0; s_fl = 0; s_rdy = 0; s_done = 0;
    s_mv = '0; s_ma = '0; s_hd = '0; s_hv = '0;
    en = 0; fl = 0; rdy = 0; done = 0; mv = '0; ma = '0; hd = '0; hv = '0;
  endtask

  task automatic model_reset();
    q.delete();
    m_state = 0; m_outst = 0; m_drop = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pf_valid"}, pf_valid_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_lock"}, hist_lock_o, 1);
    chk({tag, "_take"}, hist_take_o, 0);
    chk({tag, "_drop"}, drop_cnt_o, 0);
  endtask

  // Monitor: every accepted request must match the oldest expected candidate.
  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (rst_n && pf_valid_o && rdy) begin
        if (q.size() == 0) chk("mon_spurious_issue", pf_valid_o, 0);
        else chk("mon_issue_addr", pf_addr_o, q.pop_front());
      end
    end
  end

  // One clock: apply stimulus, compare against the model, advance the model.
  task automatic step();
    logic [31:0] seen[$];
    logic [31:0] pushes[$];
    logic [31:0] accl[$];
    logic [31:0] c;
    int ndrop, old_outst;
    bit act, dup, hit, exp_valid, exp_hs;
    @(posedge clk);
    #1;
    en = s_en; fl = s_fl; rdy = s_rdy; done = s_done;
    mv = s_mv; ma = s_ma; hd = s_hd; hv = s_hv;
    #1;
    act = (m_state == 1);
    ndrop = 0;
    for (int i = 0; i < NI; i++) begin
      if (act && !s_fl && s_mv[i]) begin
        c = next_line(s_ma[i]);
        dup = 0;
        foreach (seen[k]) if (seen[k] == c) dup = 1;
        if (!dup) begin
          seen.push_back(c);
          hit = 0;
          for (int h = 0; h < NH; h++) if (s_hv[h] && s_hd[h] == c) hit = 1;
          foreach (q[k]) if (q[k] == c) hit = 1;
          if (hit) pushes.push_back(c);
          else if (q.size() + accl.size() < ND) begin
            accl.push_back(c);
            pushes.push_back(c);
          end else ndrop++;
        end
      end
    end
    exp_valid = act && (q.size() > 0) && (m_outst < MO);
    exp_hs = exp_valid && s_rdy;
    chk("lock", hist_lock_o, !act);
    chk("hist_flush", hist_flush_o, s_fl);
    chk("busy", busy_o, m_state != 0);
    chk("drop_cnt", drop_cnt_o, m_drop);
    chk("pf_valid", pf_valid_o, exp_valid);
    if (exp_valid) chk("pf_addr", pf_addr_o, q[0]);
    chk("hist_take", hist_take_o, (1 << pushes.size()) - 1);
    foreach (pushes[k]) chk("hist_addr", hist_addr_o[k], pushes[k]);
    #2;
    m_drop = (m_drop + ndrop > 65535) ? 65535 : m_drop + ndrop;
    old_outst = m_outst;
    m_outst = m_outst + (exp_hs ? 1 : 0) - ((s_done && m_outst > 0) ? 1 : 0);
    case (m_state)
      0: if (s_en && !s_fl) m_state = 1;
      1: if (s_fl || !s_en) begin m_state = 2; q.delete(); end
         else foreach (accl[k]) q.push_back(accl[k]);
      default: if (old_outst == 0 && !s_fl) m_state = 0;
    endcase
  endtask

  task automatic miss2(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1);
    s_mv = v; s_ma[0] = a0; s_ma[1] = a1;
  endtask

  task automatic mid_reset(input string tag);
    @(posedge clk);
    #5;
    rst_n = 0;
    #1;
    chk({tag, "_pf_valid_async"}, pf_valid_o, 0);
    chk({tag, "_busy_async"}, busy_o, 0);
    chk({tag, "_drop_async"}, drop_cnt_o, 0);
    clear_stim();
    model_reset();
    #2;
    rst_n = 1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, n_total %0d", n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    clear_stim();
    model_reset();
    #12;
    chk_reset_outputs("rst");
    chk("rst_hist_flush", hist_flush_o, 0);
    #11;
    rst_n = 1;

    // next-line candidate, history push and first issue
    s_en = 1; step();
    miss2(2'b01, 32'h1008, 32'h0); step();
    chk("tp1_take", hist_take_o, 2'b01);
    chk("tp1_addr", hist_addr_o[0], 32'h1040);
    miss2(2'b00, 0, 0); s_rdy = 1; step();
    chk("tp1_valid", pf_valid_o, 1);
    chk("tp1_pf_addr", pf_addr_o, 32'h1040);
    s_rdy = 0; step();
    chk("tp1_empty", pf_valid_o, 0);
    s_done = 1; step(); step(); s_done = 0;

    // lane dedup, then history hit re-pushed without enqueue
    miss2(2'b11, 32'h2000, 32'h2010); step();
    chk("tp2_take", hist_take_o, 2'b01);
    miss2(2'b00, 0, 0); s_rdy = 1; step();
    s_rdy = 0; s_hv[0] = 1; s_hd[0] = 32'h2040;
    miss2(2'b01, 32'h2000, 0); step();
    chk("tp2_repush", hist_take_o, 2'b01);
    miss2(2'b00, 0, 0); s_hv = '0; step();
    chk("tp2_no_enq", pf_valid_o, 0);
    s_done = 1; step(); step(); s_done = 0;

    // overflow with a stalled consumer
    miss2(2'b11, 32'h3000, 32'h3100); step();
    miss2(2'b11, 32'h3200, 32'h3300); step();
    miss2(2'b11, 32'h3400, 32'h3500); step();
    miss2(2'b00, 0, 0); step();
    chk("tp3_drop", drop_cnt_o, 2);
    chk("tp3_stable", pf_addr_o, 32'h3040);

    // outstanding limit
    s_rdy = 1; step(); step(); step();
    chk("tp4_limit", pf_valid_o, 0);
    s_done = 1; step();
    s_done = 0; step();
    chk("tp4_third", pf_valid_o, 1);
    s_rdy = 0; s_done = 1; step();
    s_rdy = 1; s_done = 1; step();
    s_done = 0; step();

    // flush with pending and outstanding
    s_rdy = 0; miss2(2'b11, 32'h5000, 32'h5100); step();
    s_rdy = 1; miss2(2'b01, 32'h5200, 0); step();
    miss2(2'b01, 32'h5300, 0); step();
    miss2(2'b00, 0, 0); s_rdy = 0; s_fl = 1; s_en = 0; step();
    chk("tp5_hist_flush", hist_flush_o, 1);
    s_fl = 0; step();
    chk("tp5_busy", busy_o, 1);
    chk("tp5_valid", pf_valid_o, 0);
    s_done = 1; step(); step(); s_done = 0; step(); step();
    chk("tp5_idle", busy_o, 0);

    // all-ones line wraps to zero
    s_en = 1; step();
    miss2(2'b01, 32'hFFFF_FFC0, 0); step();
    chk("tp6_wrap", hist_addr_o[0], 32'h0);
    miss2(2'b00, 0, 0); s_rdy = 1; step();
    chk("tp6_pf_addr", pf_addr_o, 32'h0);
    chk("tp6_valid", pf_valid_o, 1);

    // randomized traffic with occasional asynchronous reset
    for (int cyc = 0; cyc < 3000; cyc++) begin
      s_en = ($urandom_range(0, 19) != 0);
      s_fl = ($urandom_range(0, 39) == 0);
      s_rdy = $urandom_range(0, 1);
      s_done = (m_outst > 0 && $urandom_range(0, 9) < 4) || ($urandom_range(0, 49) == 0);
      s_mv = NI'($urandom_range(0, 3));
      for (int i = 0; i < NI; i++)
        s_ma[i] = ($urandom_range(0, 63) == 0) ? 32'hFFFF_FFC0 + $urandom_range(0, 63)
                : 32'h8000 + $urandom_range(0, 11) * 64 + $urandom_range(0, 63);
      for (int h = 0; h < NH; h++) begin
        s_hv[h] = ($urandom_range(0, 3) == 0);
        s_hd[h] = 32'h8040 + $urandom_range(0, 11) * 64;
      end
      step();
      if (cyc % 700 == 350) begin
        s_rdy = 0; s_fl = 0; s_en = 1; s_done = 0;
        miss2(2'b11, 32'hA000, 32'hA100); step();
        mid_reset("burst");
      end
    end

    // drop counter saturation
    mid_reset("sat");
    s_en = 1; step();
    for (int cyc = 0; cyc < 32800; cyc++) begin
      miss2(2'b11, 32'h0100_0000 + cyc * 128, 32'h0100_0040 + cyc * 128);
      step();
    end
    miss2(2'b00, 0, 0); step();
    chk("sat_drop", drop_cnt_o, 16'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
